// File: rtl/parity_pkg.sv
// Shared parity-mode constants and the word check-bit helper for the frame checker.
package parity_pkg;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // Returns 1 when the low 'width' bits of 'word' violate the selected parity.
  function automatic logic parity_check_bit(input logic [31:0] word,
                                            input int          width,
                                            input logic        odd);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (^(word & mask)) ^ odd;
  endfunction

endpackage

// File: rtl/parity_word_check.sv
// Combinational parity check of one DATA_W-bit word, MSB being the parity bit.
module parity_word_check
  import parity_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int ODD_PARITY = 0
) (
  input  logic [DATA_W-1:0] data,
  output logic              err
);

  localparam logic ODD_MODE = (ODD_PARITY != PARITY_EVEN);

  assign err = parity_check_bit(32'(data), DATA_W, ODD_MODE);

endmodule

// File: rtl/parity_frame_checker.sv
// Pipelined parity checker with frame grouping and a saturating error count.
// Optional feature macro: PARITY_ERR_COUNT_EN builds the error counter; otherwise err_count is 0.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int FRAME_LEN  = 4,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-2:0] out_data,
  output logic              out_err,
  output logic              out_last,
  output logic              out_frame_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int POS_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

  logic             word_err;
  logic             accept;
  logic             last_word;
  logic [POS_W-1:0] pos_reg;
  logic             frame_acc_reg;
  logic [POS_W-1:0] base_pos;
  logic             base_acc;

  parity_word_check #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_word_check (
    .data (in_data),
    .err  (word_err)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the accept cycle makes the incoming word the first of a fresh frame.
  assign base_pos  = clear ? '0 : pos_reg;
  assign base_acc  = clear ? 1'b0 : frame_acc_reg;
  assign last_word = (base_pos == LAST_POS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_err       <= 1'b0;
      out_last      <= 1'b0;
      out_frame_err <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_data      <= in_data[DATA_W-2:0];
      out_err       <= word_err;
      out_last      <= last_word;
      out_frame_err <= last_word && (base_acc || word_err);
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_reg       <= '0;
      frame_acc_reg <= 1'b0;
    end else if (accept) begin
      pos_reg       <= last_word ? '0 : base_pos + POS_W'(1);
      frame_acc_reg <= last_word ? 1'b0 : (base_acc || word_err);
    end else if (clear) begin
      pos_reg       <= '0;
      frame_acc_reg <= 1'b0;
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= (accept && word_err) ? CNT_W'(1) : '0;
    end else if (accept && word_err && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign err_count = count_reg;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench: two checker configurations driven by shared stimulus, compared
// against a word/frame-level reference model.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [5:0] in_data = 6'd0;

  logic       in_ready_a, out_valid_a, out_err_a, out_last_a, out_ferr_a;
  logic [4:0] out_data_a;
  logic [1:0] cnt_a;
  logic       in_ready_b, out_valid_b, out_err_b, out_last_b, out_ferr_b;
  logic [4:0] out_data_b;
  logic [2:0] cnt_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(6), .FRAME_LEN(4), .ODD_PARITY(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_err(out_err_a), .out_last(out_last_a), .out_frame_err(out_ferr_a), .err_count(cnt_a)
  );

  parity_frame_checker #(.DATA_W(6), .FRAME_LEN(1), .ODD_PARITY(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_err(out_err_b), .out_last(out_last_b), .out_frame_err(out_ferr_b), .err_count(cnt_b)
  );

  // Reference model state per configuration (0 = dut_a, 1 = dut_b)
  bit         m_valid [2];
  bit         m_fresh [2];
  logic [4:0] m_data  [2];
  bit         m_err   [2];
  bit         m_last  [2];
  bit         m_ferr  [2];
  int         m_cnt   [2];
  int         m_widx  [2];
  int         m_ferrs [2];

  function automatic int cfg_frame_len(int d); return (d == 0) ? 4 : 1; endfunction
  function automatic int cfg_odd(int d);       return (d == 0) ? 0 : 1; endfunction
  function automatic int cfg_cnt_max(int d);   return (d == 0) ? 3 : 7; endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(int d, bit acc);
    bit e;
    bit last;
    if (!rst_n) begin
      m_valid[d] = 0; m_data[d] = '0; m_err[d] = 0; m_last[d] = 0; m_ferr[d] = 0;
      m_cnt[d] = 0; m_widx[d] = 0; m_ferrs[d] = 0; m_fresh[d] = 1;
      return;
    end
    if (clear) begin
      m_widx[d] = 0; m_ferrs[d] = 0; m_cnt[d] = 0;
    end
    if (acc) begin
      e = (($countones(in_data) % 2) != cfg_odd(d));
      if (e) m_ferrs[d]++;
      last = (m_widx[d] == cfg_frame_len(d) - 1);
      m_valid[d] = 1;
      m_fresh[d] = 0;
      m_data[d]  = in_data[4:0];
      m_err[d]   = e;
      m_last[d]  = last;
      m_ferr[d]  = last && (m_ferrs[d] > 0);
      if (last) begin
        m_widx[d] = 0; m_ferrs[d] = 0;
      end else begin
        m_widx[d]++;
      end
      if (e && m_cnt[d] < cfg_cnt_max(d)) m_cnt[d]++;
    end else if (out_ready) begin
      m_valid[d] = 0;
    end
  endfunction

  task automatic compare_outputs(int d);
    logic       v, e, l, f;
    logic [4:0] dat;
    logic [2:0] c;
    int         exp_cnt;
    string      n;
    n = (d == 0) ? "a" : "b";
    if (d == 0) begin
      v = out_valid_a; e = out_err_a; l = out_last_a; f = out_ferr_a; dat = out_data_a; c = {1'b0, cnt_a};
    end else begin
      v = out_valid_b; e = out_err_b; l = out_last_b; f = out_ferr_b; dat = out_data_b; c = cnt_b;
    end
`ifdef PARITY_ERR_COUNT_EN
    exp_cnt = m_cnt[d];
`else
    exp_cnt = 0;
`endif
    chk({"out_valid_", n}, 32'(v), 32'(m_valid[d]));
    if (m_valid[d] || m_fresh[d]) begin
      chk({"out_data_", n},      32'(dat), 32'(m_data[d]));
      chk({"out_err_", n},       32'(e),   32'(m_err[d]));
      chk({"out_last_", n},      32'(l),   32'(m_last[d]));
      chk({"out_frame_err_", n}, 32'(f),   32'(m_ferr[d]));
    end
    chk({"err_count_", n}, 32'(c), 32'(exp_cnt));
  endtask

  // One clock: check in_ready before the edge, advance model at the edge, check outputs after.
  task automatic step();
    bit acc;
    #1;
    chk("in_ready_a", 32'(in_ready_a), 32'(!m_valid[0] || out_ready));
    chk("in_ready_b", 32'(in_ready_b), 32'(!m_valid[1] || out_ready));
    acc = in_valid && (!m_valid[0] || out_ready);
    @(posedge clk);
    model_edge(0, acc);
    model_edge(1, acc);
    #1;
    compare_outputs(0);
    compare_outputs(1);
    $display("step t=%0t rst_n=%0b clr=%0b acc=%0b in=%b rdy=%0b | a: v=%0b d=%b e=%0b l=%0b f=%0b c=%0d | b: v=%0b e=%0b c=%0d",
             $time, rst_n, clear, acc, in_data, out_ready, out_valid_a, out_data_a, out_err_a,
             out_last_a, out_ferr_a, cnt_a, out_valid_b, out_err_b, cnt_b);
  endtask

  task automatic send(logic [5:0] w, bit clr);
    in_valid = 1'b1; in_data = w; clear = clr; out_ready = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic idle(bit clr);
    in_valid = 1'b0; clear = clr; out_ready = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_fresh[d] = 1; m_data[d] = '0; m_err[d] = 0; m_last[d] = 0;
      m_ferr[d] = 0; m_cnt[d] = 0; m_widx[d] = 0; m_ferrs[d] = 0;
    end

    // Reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Basic even-parity words
    send(6'b000011, 0);
    send(6'b000001, 0);
    idle(0);

    // Frame with one bad word, then a clean frame
    idle(1);
    send(6'b000000, 0);
    send(6'b000001, 0);
    send(6'b000000, 0);
    send(6'b000000, 0);
    for (int i = 0; i < 4; i++) send(6'b000000, 0);
    idle(0);

    // Backpressure for three cycles, then release
    in_valid = 1'b1; in_data = 6'b100001; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 6'(i + 5);
      step();
    end
    out_ready = 1'b1; in_data = 6'b110000;
    step();
    idle(0);

    // Saturation: five erroneous words
    idle(1);
    for (int i = 0; i < 5; i++) send(6'b000001, 0);
    idle(0);

    // Clear coinciding with erroneous word 2 of a frame
    idle(1);
    send(6'b000000, 0);
    send(6'b000000, 0);
    send(6'b000001, 1);
    for (int i = 0; i < 4; i++) send(6'b000000, 0);
    idle(0);

    // Reset mid-frame, then a fresh frame
    send(6'b000001, 0);
    send(6'b000011, 0);
    rst_n = 1'b0; in_valid = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(6'b000101, 0);
    idle(0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 49) != 0);
      in_data   = 6'($urandom);
      step();
    end
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
